adc_scan_ctrl: RTL

Multi-channel scan sequencer for the single sigma-delta ADC. It drives the analog mux select in front of the comparator and discards post-switch samples while the RC integrator settles. It captures one settled sample per enabled channel into a per-channel result register and flags over-threshold channels as sticky faults for the gate-driver protection logic. It sits between the ADC (consumes `digital_out`/`sample_rdy`) and the gate-driver control/fault logic.

---
 rtl/adc_ctrl_pkg.sv | 23 ++
 rtl/adc_scan_ctrl_if.sv | 27 ++
 rtl/ch_next_find.sv | 27 ++
 rtl/adc_scan_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared types and defaults for the ADC scan sequencer.
package adc_ctrl_pkg;

    // Scan sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        NEXT    = 3'd4
    } scan_state_t;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_ADC_WIDTH = 8;
    localparam int DEF_DISCARD   = 2;

    // Mux select width needed to address DEF_NUM_CH channels
    localparam int DEF_CH_BITS   = (DEF_NUM_CH <= 2) ? 1 : $clog2(DEF_NUM_CH);

    // Discard counter width; DISCARD is limited to 0..15
    localparam int DISC_BITS     = 4;

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// ADC-side bus: mux select toward the analog front end, sample data/strobe back.
interface adc_scan_ctrl_if
    import adc_ctrl_pkg::*;
#(
    parameter int CH_BITS   = DEF_CH_BITS,
    parameter int ADC_WIDTH = DEF_ADC_WIDTH
) ();

    logic [CH_BITS-1:0]   mux_sel;
    logic [ADC_WIDTH-1:0] adc_data;
    logic                 adc_rdy;

    // Scan controller side
    modport master (
        output mux_sel,
        input  adc_data,
        input  adc_rdy
    );

    // ADC / analog mux side
    modport slave (
        input  mux_sel,
        output adc_data,
        output adc_rdy
    );

endinterface

// File: rtl/ch_next_find.sv
// Finds the lowest set mask bit strictly above cur, or the lowest set bit overall when first=1.
module ch_next_find
    import adc_ctrl_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CH_BITS = DEF_CH_BITS
) (
    input  logic [NUM_CH-1:0]  mask,
    input  logic [CH_BITS-1:0] cur,
    input  logic               first,
    output logic               found,
    output logic [CH_BITS-1:0] idx
);

    // Scan from the top down so the lowest qualifying index is the last one written
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (CH_BITS'(i) > cur))) begin
                found = 1'b1;
                idx   = CH_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel scan sequencer: steps the analog mux over enabled channels,
// drops settling samples after each switch, captures one sample per channel
// and raises sticky over-threshold faults.
module adc_scan_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CH_BITS   = DEF_CH_BITS,
    parameter int ADC_WIDTH = DEF_ADC_WIDTH,
    parameter int DISCARD   = DEF_DISCARD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic                        start,
    input  logic                        cont,
    input  logic [ADC_WIDTH-1:0]        thresh,
    input  logic                        fault_clr,
    adc_scan_ctrl_if.master             adc,
    output logic [NUM_CH*ADC_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]           ch_valid,
    output logic [NUM_CH-1:0]           fault,
    output logic                        busy,
    output logic                        scan_done
);

    localparam logic [DISC_BITS-1:0] DISC_LAST = DISC_BITS'(DISCARD);

    scan_state_t            state_reg;
    logic [CH_BITS-1:0]     cur_reg;
    logic [CH_BITS-1:0]     mux_sel_reg;
    logic [NUM_CH-1:0]      en_q_reg;
    logic [DISC_BITS-1:0]   disc_cnt_reg;
    logic [ADC_WIDTH-1:0]   ch_data_reg [NUM_CH];
    logic [NUM_CH-1:0]      ch_valid_reg;
    logic [NUM_CH-1:0]      fault_reg;
    logic                   scan_done_reg;

    logic                   nxt_found;
    logic [CH_BITS-1:0]     nxt_idx;
    logic                   first_found;
    logic [CH_BITS-1:0]     first_idx;

    // Next enabled channel within the latched scan mask
    ch_next_find #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_find_next (
        .mask  (en_q_reg),
        .cur   (cur_reg),
        .first (1'b0),
        .found (nxt_found),
        .idx   (nxt_idx)
    );

    // First enabled channel of the live mask, used when a scan is latched
    ch_next_find #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_find_first (
        .mask  (ch_en),
        .cur   ('0),
        .first (1'b1),
        .found (first_found),
        .idx   (first_idx)
    );

    // Scan sequencer with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            mux_sel_reg   <= '0;
            en_q_reg      <= '0;
            disc_cnt_reg  <= '0;
            ch_valid_reg  <= '0;
            fault_reg     <= '0;
            scan_done_reg <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                ch_data_reg[k] <= '0;
            end
        end else begin
            scan_done_reg <= 1'b0;
            // A fault set later in this block overrides the clear for its bit
            if (fault_clr) begin
                fault_reg <= '0;
            end
            case (state_reg)
                IDLE: begin
                    if ((start || cont) && first_found) begin
                        en_q_reg  <= ch_en;
                        cur_reg   <= first_idx;
                        state_reg <= SELECT;
                    end
                end
                SELECT: begin
                    mux_sel_reg  <= cur_reg;
                    disc_cnt_reg <= '0;
                    state_reg    <= (DISCARD == 0) ? CAPTURE : SETTLE;
                end
                SETTLE: begin
                    if (adc.adc_rdy) begin
                        disc_cnt_reg <= disc_cnt_reg + 1'b1;
                        if (disc_cnt_reg + 1'b1 == DISC_LAST) begin
                            state_reg <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (adc.adc_rdy) begin
                        ch_data_reg[cur_reg]  <= adc.adc_data;
                        ch_valid_reg[cur_reg] <= 1'b1;
                        if (adc.adc_data > thresh) begin
                            fault_reg[cur_reg] <= 1'b1;
                        end
                        // Pulse lands in the NEXT cycle when this was the last channel
                        scan_done_reg <= !nxt_found;
                        state_reg     <= NEXT;
                    end
                end
                NEXT: begin
                    if (nxt_found) begin
                        cur_reg   <= nxt_idx;
                        state_reg <= SELECT;
                    end else if (cont && first_found) begin
                        en_q_reg  <= ch_en;
                        cur_reg   <= first_idx;
                        state_reg <= SELECT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Flatten the per-channel result registers onto the output bus
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_data
            assign ch_data[gi*ADC_WIDTH +: ADC_WIDTH] = ch_data_reg[gi];
        end
    endgenerate

    assign adc.mux_sel = mux_sel_reg;
    assign ch_valid    = ch_valid_reg;
    assign fault       = fault_reg;
    assign busy        = (state_reg != IDLE);
    assign scan_done   = scan_done_reg;

endmodule
